// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the regfile write port, WB priority over a debug FIFO drained on idle cycles, stall on starvation; REGARB_STATS_EN builds conflict_cnt
module regfile_wr_arbiter #(
  parameter int BUS_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_wr,
  input  logic [4:0]           wb_addr,
  input  logic [BUS_WIDTH-1:0] wb_data,
  input  logic                 dbg_valid,
  output logic                 dbg_ready,
  input  logic [4:0]           dbg_addr,
  input  logic [BUS_WIDTH-1:0] dbg_data,
  output logic                 rf_wr,
  output logic [4:0]           rf_addr,
  output logic [BUS_WIDTH-1:0] rf_data,
  output logic                 stall_req,
  output logic                 dbg_grant,
  output logic [15:0]          conflict_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  logic [4:0]           addr_mem [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [7:0]           wait_cnt, wait_nxt;
  logic                 empty, full, push, pop, blocked;
  logic [4:0]           head_addr;
  assign empty     = wr_ptr == rd_ptr;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dbg_ready = !rst && !full;
  assign push      = dbg_valid && dbg_ready;
  assign pop       = !rst && !wb_wr && !empty;
  assign blocked   = !empty && wb_wr;
  assign dbg_grant = pop;
  assign head_addr = addr_mem[rd_ptr[AW-1:0]];
  assign rf_wr     = !rst && (wb_wr || (pop && head_addr != 5'd0));
  assign rf_addr   = wb_wr ? wb_addr : head_addr;
  assign rf_data   = wb_wr ? wb_data : data_mem[rd_ptr[AW-1:0]];
  assign wait_nxt  = pop ? 8'd0 : (blocked && wait_cnt != MW) ? wait_cnt + 8'd1 : wait_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wait_cnt  <= '0;
      stall_req <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + (AW+1)'(push);
      rd_ptr    <= rd_ptr + (AW+1)'(pop);
      wait_cnt  <= wait_nxt;
      stall_req <= !pop && (stall_req || wait_nxt == MW);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[AW-1:0]] <= dbg_addr;
      data_mem[wr_ptr[AW-1:0]] <= dbg_data;
    end
  end
`ifdef REGARB_STATS_EN
  logic [15:0] conf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) conf <= '0;
    else conf <= (blocked && conf != 16'hFFFF) ? conf + 16'd1 : conf;
  end
  assign conflict_cnt = conf;
`else
  assign conflict_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed scenarios plus randomized traffic against a queue-based reference model
module tb_regfile_wr_arbiter;
  localparam int DEPTH = 4;
  localparam int MAXW  = 8;
  logic clk = 0, rst = 1, wb_wr = 0, dbg_valid = 0;
  logic [4:0] wb_addr = 0, dbg_addr = 0, rf_addr;
  logic [31:0] wb_data = 0, dbg_data = 0, rf_data;
  logic dbg_ready, rf_wr, stall_req, dbg_grant;
  logic [15:0] conflict_cnt;
  int n_cmp = 0, n_err = 0;
  logic [36:0] mq[$];
  int m_blk = 0, m_conf = 0;
  bit m_stall = 0;

  regfile_wr_arbiter #(.BUS_WIDTH(32), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .stall_req(stall_req),
    .dbg_grant(dbg_grant), .conflict_cnt(conflict_cnt));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] exp_conf();
`ifdef REGARB_STATS_EN
    return 16'(m_conf);
`else
    return 16'h0;
`endif
  endfunction

  task automatic tick();
    int n;
    bit pop, push;
    n = mq.size();
    pop = !wb_wr && n > 0;
    push = dbg_valid && n < DEPTH;
    if (n > 0 && wb_wr) begin
      if (m_blk < MAXW) m_blk++;
      if (m_conf < 65535) m_conf++;
    end
    m_stall = pop ? 1'b0 : (m_stall || m_blk == MAXW);
    if (pop) begin
      void'(mq.pop_front());
      m_blk = 0;
    end
    if (push) mq.push_back({dbg_addr, dbg_data});
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    m_blk = 0;
    m_conf = 0;
    m_stall = 0;
  endtask

  task automatic test_reset();
    wb_wr = 1; wb_addr = 9; wb_data = 32'h1234;
    #2;
    n_cmp++;
    if ({dbg_ready, rf_wr, dbg_grant, stall_req, conflict_cnt} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_hold got ready=%b wr=%b grant=%b stall=%b conf=%h want all 0", dbg_ready, rf_wr, dbg_grant, stall_req, conflict_cnt);
    end
    @(posedge clk); #1;
    rst = 0; wb_wr = 0;
    model_clear();
    #1;
    n_cmp++;
    if ({dbg_ready, rf_wr, dbg_grant, stall_req} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_release got ready=%b wr=%b grant=%b stall=%b want 1 0 0 0", dbg_ready, rf_wr, dbg_grant, stall_req);
    end
    tick();
  endtask

  task automatic test_wb_only();
    wb_wr = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF; dbg_valid = 0;
    #1;
    n_cmp++;
    if ({rf_wr, rf_addr, rf_data, dbg_grant} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
      n_err++;
      $display("FAIL wb_only got wr=%b addr=%0d data=%h grant=%b want 1 5 deadbeef 0", rf_wr, rf_addr, rf_data, dbg_grant);
    end
    tick();
    wb_wr = 0;
  endtask

  task automatic test_debug_idle();
    wb_wr = 0; dbg_valid = 1; dbg_addr = 3; dbg_data = 32'h11;
    #1;
    n_cmp++;
    if ({dbg_ready, rf_wr, dbg_grant} !== 3'b100) begin
      n_err++;
      $display("FAIL dbg_push_cycle got ready=%b wr=%b grant=%b want 1 0 0", dbg_ready, rf_wr, dbg_grant);
    end
    tick();
    dbg_valid = 0;
    #1;
    n_cmp++;
    if ({rf_wr, rf_addr, rf_data, dbg_grant} !== {1'b1, 5'd3, 32'h11, 1'b1}) begin
      n_err++;
      $display("FAIL dbg_idle_grant got wr=%b addr=%0d data=%h grant=%b want 1 3 11 1", rf_wr, rf_addr, rf_data, dbg_grant);
    end
    tick();
    n_cmp++;
    if ({rf_wr, dbg_grant} !== 2'b00) begin
      n_err++;
      $display("FAIL dbg_idle_empty got wr=%b grant=%b want 0 0", rf_wr, dbg_grant);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < DEPTH + 2 && mq.size() > 0; k++) begin
      wb_wr = 0; dbg_valid = 0;
      #1;
      n_cmp++;
      if ({dbg_grant, rf_wr, rf_addr, rf_data} !== {1'b1, mq[0][36:32] != 5'd0, mq[0]}) begin
        n_err++;
        $display("FAIL %s got grant=%b wr=%b addr=%0d data=%h want 1 %b %0d %h", name, dbg_grant, rf_wr, rf_addr, rf_data, mq[0][36:32] != 5'd0, mq[0][36:32], mq[0][31:0]);
      end
      tick();
    end
  endtask

  task automatic test_fill();
    wb_wr = 1; wb_addr = 1; wb_data = 32'hAAAA;
    for (int i = 0; i < DEPTH; i++) begin
      dbg_valid = 1; dbg_addr = 5'(10 + i); dbg_data = 32'hF000 + i;
      tick();
    end
    dbg_addr = 20; dbg_data = 32'hE5;
    #1;
    n_cmp++;
    if (dbg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full got ready=%b want 0", dbg_ready);
    end
    tick();
    wb_wr = 0;
    #1;
    n_cmp++;
    if ({dbg_ready, dbg_grant, rf_addr, rf_data} !== {1'b0, 1'b1, 5'd10, 32'hF000}) begin
      n_err++;
      $display("FAIL fill_first_pop got ready=%b grant=%b addr=%0d data=%h want 0 1 10 f000", dbg_ready, dbg_grant, rf_addr, rf_data);
    end
    tick();
    #1;
    n_cmp++;
    if (dbg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL fill_accept_after_pop got ready=%b want 1", dbg_ready);
    end
    tick();
    dbg_valid = 0;
    drain("fill_drain");
    n_cmp++;
    if (stall_req !== m_stall) begin
      n_err++;
      $display("FAIL fill_stall got %b want %b", stall_req, m_stall);
    end
  endtask

  task automatic test_starvation();
    wb_wr = 1; dbg_valid = 1; dbg_addr = 7; dbg_data = 32'h77;
    tick();
    dbg_valid = 0;
    for (int i = 1; i <= MAXW; i++) begin
      n_cmp++;
      if (stall_req !== 1'b0) begin
        n_err++;
        $display("FAIL starve_early cycle=%0d got stall=%b want 0", i, stall_req);
      end
      tick();
    end
    n_cmp++;
    if ({stall_req, conflict_cnt} !== {1'b1, exp_conf()}) begin
      n_err++;
      $display("FAIL starve_assert got stall=%b conf=%h want 1 %h", stall_req, conflict_cnt, exp_conf());
    end
    wb_wr = 0;
    #1;
    n_cmp++;
    if ({dbg_grant, stall_req, rf_addr} !== {1'b1, 1'b1, 5'd7}) begin
      n_err++;
      $display("FAIL starve_grant got grant=%b stall=%b addr=%0d want 1 1 7", dbg_grant, stall_req, rf_addr);
    end
    tick();
    n_cmp++;
    if ({dbg_grant, stall_req} !== 2'b00) begin
      n_err++;
      $display("FAIL starve_release got grant=%b stall=%b want 0 0", dbg_grant, stall_req);
    end
  endtask

  task automatic test_x0();
    wb_wr = 0; dbg_valid = 1; dbg_addr = 0; dbg_data = 32'hFF;
    tick();
    dbg_valid = 0;
    #1;
    n_cmp++;
    if ({dbg_grant, rf_wr} !== 2'b10) begin
      n_err++;
      $display("FAIL x0_filter got grant=%b wr=%b want 1 0", dbg_grant, rf_wr);
    end
    tick();
    n_cmp++;
    if ({dbg_grant, rf_wr} !== 2'b00) begin
      n_err++;
      $display("FAIL x0_popped got grant=%b wr=%b want 0 0", dbg_grant, rf_wr);
    end
  endtask

  task automatic test_reset_mid_queue();
    wb_wr = 1; wb_addr = 2;
    for (int i = 0; i < 3; i++) begin
      dbg_valid = 1; dbg_addr = 5'(4 + i); dbg_data = 32'hC0 + i;
      tick();
    end
    dbg_valid = 0;
    rst = 1;
    #2;
    n_cmp++;
    if ({dbg_ready, rf_wr} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_hold got ready=%b wr=%b want 0 0", dbg_ready, rf_wr);
    end
    rst = 0; wb_wr = 0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({dbg_ready, rf_wr, dbg_grant, stall_req, conflict_cnt} !== 20'h80000) begin
        n_err++;
        $display("FAIL rst_mid_after got ready=%b wr=%b grant=%b stall=%b conf=%h want 1 0 0 0 0", dbg_ready, rf_wr, dbg_grant, stall_req, conflict_cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit e_grant, e_wr;
    for (int c = 0; c < 400; c++) begin
      wb_wr = ($urandom_range(0, 9) < 6);
      wb_addr = 5'($urandom);
      wb_data = $urandom;
      if (!(dbg_valid && mq.size() >= DEPTH)) begin
        dbg_valid = $urandom_range(0, 1);
        dbg_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        dbg_data = $urandom;
      end
      #1;
      e_grant = !wb_wr && mq.size() > 0;
      e_wr = wb_wr || (e_grant && mq[0][36:32] != 5'd0);
      n_cmp++;
      if ({rf_wr, dbg_grant, dbg_ready, stall_req, conflict_cnt} !== {e_wr, e_grant, mq.size() < DEPTH, m_stall, exp_conf()}) begin
        n_err++;
        $display("FAIL rand_ctrl c=%0d got wr=%b grant=%b ready=%b stall=%b conf=%h want %b %b %b %b %h", c, rf_wr, dbg_grant, dbg_ready, stall_req, conflict_cnt, e_wr, e_grant, mq.size() < DEPTH, m_stall, exp_conf());
      end
      if (e_wr) begin
        n_cmp++;
        if ({rf_addr, rf_data} !== (wb_wr ? {wb_addr, wb_data} : mq[0])) begin
          n_err++;
          $display("FAIL rand_data c=%0d got addr=%0d data=%h want %h", c, rf_addr, rf_data, wb_wr ? {wb_addr, wb_data} : mq[0]);
        end
      end
      tick();
    end
    dbg_valid = 0;
    drain("rand_drain");
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_debug_idle();
    test_fill();
    test_starvation();
    test_x0();
    test_reset_mid_queue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
